hand_bbox: RTL and testbench

Upstream stage of the finger-counting block. It scans the binarized skin/edge image one pixel at a time and finds the bounding box of the hand: the minimum and maximum x and y of qualified white pixels in each frame. The box is widened by a margin and published at frame end as `left/right/top/bottom`. The finger counter then uses it as its scan window for the following frames.

---
 rtl/hand_bbox.sv | 244 ++++++++++++++++++++++++
 tb/tb_hand_bbox.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hand_bbox.sv
// hand_bbox: per-frame bounding box of run-filtered foreground pixels.
// Scans a binarized pixel stream, tracks min/max x/y of qualified pixels,
// and at frame end publishes the box widened by MARGIN and clamped to the frame.
// Optional feature macro: HAND_BBOX_SMOOTH_EN averages each new accepted box
// with the previous one (the first accepted box after reset is loaded as is).
//
// Stream protocol: there is no backpressure. A sample is consumed on every
// vga_clk edge where pixel_en is high and the coordinates lie inside the
// active area. frame_done is a one-cycle qualifier meaning left/right/top/
// bottom, bbox_valid and pixel_count were just updated; they then hold until
// the next frame_done.
module hand_bbox #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int RUN_MIN    = 4,
  parameter int MIN_PIXELS = 200,
  parameter int MARGIN     = 10
) (
  input  logic        vga_clk,
  input  logic        rst,
  input  logic        pixel_en,
  input  logic [11:0] img_data,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  output logic [9:0]  left,
  output logic [9:0]  right,
  output logic [9:0]  top,
  output logic [9:0]  bottom,
  output logic        bbox_valid,
  output logic        frame_done,
  output logic [18:0] pixel_count,
  output logic        dbg_accum_o
);

  localparam logic [10:0] H_LIM     = 11'(H_ACTIVE);
  localparam logic [10:0] V_LIM     = 11'(V_ACTIVE);
  localparam logic [10:0] H_LAST    = 11'(H_ACTIVE - 1);
  localparam logic [10:0] V_LAST    = 11'(V_ACTIVE - 1);
  localparam logic [9:0]  H_LAST10  = 10'(H_ACTIVE - 1);
  localparam logic [9:0]  V_LAST10  = 10'(V_ACTIVE - 1);
  localparam logic [10:0] MARGIN_W  = 11'(MARGIN);
  localparam logic [9:0]  MARGIN10  = 10'(MARGIN);
  localparam logic [4:0]  RUN_MIN5  = 5'(RUN_MIN);
  localparam logic [3:0]  RUN_SAT   = 4'(RUN_MIN);
  localparam logic [9:0]  RUN_BACK  = 10'(RUN_MIN - 1);
  localparam logic [18:0] MIN_PIX_W = 19'(MIN_PIXELS);
  localparam logic [18:0] CNT_MAX   = '1;
  localparam logic [9:0]  COORD_CLR = '1;

  typedef enum logic {SYNC = 1'b0, ACCUM = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [3:0]  run_q, run_d;
  logic [9:0]  min_x_q, min_x_d, max_x_q, max_x_d;
  logic [9:0]  min_y_q, min_y_d, max_y_q, max_y_d;
  logic [18:0] cnt_q, cnt_d;
  logic [9:0]  left_q, left_d, right_q, right_d, top_q, top_d, bottom_q, bottom_d;
  logic        valid_q, valid_d, done_q, done_d;
  logic [18:0] count_q, count_d;
`ifdef HAND_BBOX_SMOOTH_EN
  logic        seeded_q, seeded_d;
`endif

  // Sample decode and the accumulator values after folding in this sample.
  logic        accepted, at_origin, at_end, is_fg, process, emit, qualify;
  logic [3:0]  run_base, run_new;
  logic [4:0]  run_inc;
  logic [9:0]  cand_min_x;
  logic [9:0]  min_x_f, max_x_f, min_y_f, max_y_f;
  logic [18:0] cnt_f;

  // Classify the current sample and compute the folded accumulators.
  always_comb begin
    accepted   = pixel_en && ({1'b0, pixel_x} < H_LIM) && ({1'b0, pixel_y} < V_LIM);
    at_origin  = (pixel_x == 10'd0) && (pixel_y == 10'd0);
    at_end     = ({1'b0, pixel_x} == H_LAST) && ({1'b0, pixel_y} == V_LAST);
    is_fg      = (img_data == 12'hfff);
    // In SYNC only the (0,0) sample is taken, and it starts a fresh frame.
    process    = accepted && ((state_q == ACCUM) || at_origin);
    emit       = accepted && (state_q == ACCUM) && at_end;
    run_base   = (pixel_x == 10'd0) ? 4'd0 : run_q;
    run_inc    = {1'b0, run_base} + 5'd1;
    qualify    = is_fg && (run_inc >= RUN_MIN5);
    run_new    = is_fg ? (qualify ? RUN_SAT : run_inc[3:0]) : 4'd0;
    // A qualifying pixel implies the run began at least RUN_MIN-1 columns left.
    cand_min_x = pixel_x - RUN_BACK;
    min_x_f    = (qualify && (cand_min_x < min_x_q)) ? cand_min_x : min_x_q;
    max_x_f    = (qualify && (pixel_x > max_x_q))    ? pixel_x    : max_x_q;
    min_y_f    = (qualify && (pixel_y < min_y_q))    ? pixel_y    : min_y_q;
    max_y_f    = (qualify && (pixel_y > max_y_q))    ? pixel_y    : max_y_q;
    cnt_f      = (qualify && (cnt_q != CNT_MAX))     ? cnt_q + 19'd1 : cnt_q;
  end

  // FSM next state: wait for the start of a frame, then track frames forever.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SYNC:  if (accepted && at_origin) state_d = ACCUM;
      ACCUM: state_d = ACCUM;
    endcase
  end

  // FSM state register.
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) state_q <= SYNC;
    else     state_q <= state_d;
  end

  // Accumulator next state: fold the sample, or clear at frame end so the
  // next (0,0) lands in fresh accumulators even on the very next cycle.
  always_comb begin
    run_d   = run_q;
    min_x_d = min_x_q;
    max_x_d = max_x_q;
    min_y_d = min_y_q;
    max_y_d = max_y_q;
    cnt_d   = cnt_q;
    if (emit) begin
      run_d   = 4'd0;
      min_x_d = COORD_CLR;
      max_x_d = 10'd0;
      min_y_d = COORD_CLR;
      max_y_d = 10'd0;
      cnt_d   = 19'd0;
    end else if (process) begin
      run_d   = run_new;
      min_x_d = min_x_f;
      max_x_d = max_x_f;
      min_y_d = min_y_f;
      max_y_d = max_y_f;
      cnt_d   = cnt_f;
    end
  end

  // Accumulator registers.
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      run_q   <= 4'd0;
      min_x_q <= COORD_CLR;
      max_x_q <= 10'd0;
      min_y_q <= COORD_CLR;
      max_y_q <= 10'd0;
      cnt_q   <= 19'd0;
    end else begin
      run_q   <= run_d;
      min_x_q <= min_x_d;
      max_x_q <= max_x_d;
      min_y_q <= min_y_d;
      max_y_q <= max_y_d;
      cnt_q   <= cnt_d;
    end
  end

  // Expanded box from the final totals (the frame-end sample included).
  logic        box_ok;
  logic [10:0] right_sum, bottom_sum;
  logic [9:0]  left_new, right_new, top_new, bottom_new;

`ifdef HAND_BBOX_SMOOTH_EN
  function automatic logic [9:0] blend(input logic [9:0] prev, input logic [9:0] nxt,
                                       input logic seeded);
    logic [10:0] sum;
    sum = {1'b0, prev} + {1'b0, nxt};
    return seeded ? sum[10:1] : nxt;
  endfunction
`endif

  // Result next state: update the published box on frame end.
  always_comb begin
    box_ok     = (cnt_f >= MIN_PIX_W);
    right_sum  = {1'b0, max_x_f} + MARGIN_W;
    bottom_sum = {1'b0, max_y_f} + MARGIN_W;
    left_new   = ({1'b0, min_x_f} >= MARGIN_W) ? (min_x_f - MARGIN10) : 10'd0;
    top_new    = ({1'b0, min_y_f} >= MARGIN_W) ? (min_y_f - MARGIN10) : 10'd0;
    right_new  = (right_sum  > H_LAST) ? H_LAST10 : right_sum[9:0];
    bottom_new = (bottom_sum > V_LAST) ? V_LAST10 : bottom_sum[9:0];
    left_d     = left_q;
    right_d    = right_q;
    top_d      = top_q;
    bottom_d   = bottom_q;
    valid_d    = valid_q;
    count_d    = count_q;
    done_d     = 1'b0;
`ifdef HAND_BBOX_SMOOTH_EN
    seeded_d   = seeded_q;
`endif
    if (emit) begin
      done_d  = 1'b1;
      count_d = cnt_f;
      valid_d = box_ok;
      if (box_ok) begin
`ifdef HAND_BBOX_SMOOTH_EN
        left_d   = blend(left_q,   left_new,   seeded_q);
        right_d  = blend(right_q,  right_new,  seeded_q);
        top_d    = blend(top_q,    top_new,    seeded_q);
        bottom_d = blend(bottom_q, bottom_new, seeded_q);
        seeded_d = 1'b1;
`else
        left_d   = left_new;
        right_d  = right_new;
        top_d    = top_new;
        bottom_d = bottom_new;
`endif
      end
    end
  end

  // Result registers; reset publishes the full frame as the box.
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      left_q   <= 10'd0;
      right_q  <= H_LAST10;
      top_q    <= 10'd0;
      bottom_q <= V_LAST10;
      valid_q  <= 1'b0;
      count_q  <= 19'd0;
      done_q   <= 1'b0;
`ifdef HAND_BBOX_SMOOTH_EN
      seeded_q <= 1'b0;
`endif
    end else begin
      left_q   <= left_d;
      right_q  <= right_d;
      top_q    <= top_d;
      bottom_q <= bottom_d;
      valid_q  <= valid_d;
      count_q  <= count_d;
      done_q   <= done_d;
`ifdef HAND_BBOX_SMOOTH_EN
      seeded_q <= seeded_d;
`endif
    end
  end

  assign left        = left_q;
  assign right       = right_q;
  assign top         = top_q;
  assign bottom      = bottom_q;
  assign bbox_valid  = valid_q;
  assign frame_done  = done_q;
  assign pixel_count = count_q;
  assign dbg_accum_o = (state_q == ACCUM);

endmodule

// File: tb/tb_hand_bbox.sv
// tb_hand_bbox: randomized frames against a run-based reference model.
// Small frame geometry keeps each frame to a few thousand cycles.
`timescale 1ns/1ps
module tb_hand_bbox;

  localparam int H          = 64;
  localparam int V          = 48;
  localparam int RUN_MIN    = 4;
  localparam int MIN_PIXELS = 200;
  localparam int MARGIN     = 10;
  localparam int CNT_SAT    = (1 << 19) - 1;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pixel_en = 1'b0;
  logic [11:0] img_data = 12'd0;
  logic [9:0]  pixel_x = 10'd0;
  logic [9:0]  pixel_y = 10'd0;
  logic [9:0]  left, right, top, bottom;
  logic        bbox_valid, frame_done, dbg_accum_o;
  logic [18:0] pixel_count;

  always #5 clk = ~clk;

  hand_bbox #(
    .H_ACTIVE(H), .V_ACTIVE(V), .RUN_MIN(RUN_MIN),
    .MIN_PIXELS(MIN_PIXELS), .MARGIN(MARGIN)
  ) dut (
    .vga_clk(clk), .rst(rst), .pixel_en(pixel_en), .img_data(img_data),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .left(left), .right(right), .top(top), .bottom(bottom),
    .bbox_valid(bbox_valid), .frame_done(frame_done),
    .pixel_count(pixel_count), .dbg_accum_o(dbg_accum_o)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  int          stab_msgs = 0;
  logic [59:0] exp_q[$];
  logic [59:0] mon_hold;

  // Reference model state: the image of the frame being driven and the box
  // currently published downstream.
  bit img [0:V-1][0:H-1];
  bit synced = 1'b0;
  int m_l, m_r, m_t, m_b;
`ifdef HAND_BBOX_SMOOTH_EN
  bit m_seeded;
`endif

  function automatic logic [59:0] reset_vec();
    return {1'b0, 19'd0, 10'd0, 10'(H - 1), 10'd0, 10'(V - 1)};
  endfunction

  function automatic string show(input logic [59:0] v);
    return $sformatf("valid=%0d count=%0d l=%0d r=%0d t=%0d b=%0d",
                     v[59], v[58:40], v[39:30], v[29:20], v[19:10], v[9:0]);
  endfunction

  task automatic check_vec(input string name, input logic [59:0] got, input logic [59:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %s required %s", name, show(got), show(exp));
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0b required %0b", name, got, exp);
    end
  endtask

  // Reference: scan each line for runs of white; a run of length L >= RUN_MIN
  // contributes L-RUN_MIN+1 pixels and spans its full extent [start, end].
  task automatic model_frame(output logic [59:0] e);
    int cnt, mnx, mxx, mny, mxy, x, s, len, nl, nr, nt, nb;
    bit ok;
    cnt = 0; mnx = 1023; mxx = 0; mny = 1023; mxy = 0;
    for (int y = 0; y < V; y++) begin
      x = 0;
      while (x < H) begin
        if (img[y][x]) begin
          s = x;
          while (x < H && img[y][x]) x++;
          len = x - s;
          if (len >= RUN_MIN) begin
            cnt += len - RUN_MIN + 1;
            if (s < mnx) mnx = s;
            if (x - 1 > mxx) mxx = x - 1;
            if (y < mny) mny = y;
            if (y > mxy) mxy = y;
          end
        end else begin
          x++;
        end
      end
    end
    if (cnt > CNT_SAT) cnt = CNT_SAT;
    ok = (cnt >= MIN_PIXELS);
    if (ok) begin
      nl = (mnx >= MARGIN) ? mnx - MARGIN : 0;
      nt = (mny >= MARGIN) ? mny - MARGIN : 0;
      nr = (mxx + MARGIN > H - 1) ? H - 1 : mxx + MARGIN;
      nb = (mxy + MARGIN > V - 1) ? V - 1 : mxy + MARGIN;
`ifdef HAND_BBOX_SMOOTH_EN
      if (m_seeded) begin
        nl = (m_l + nl) / 2;
        nr = (m_r + nr) / 2;
        nt = (m_t + nt) / 2;
        nb = (m_b + nb) / 2;
      end
      m_seeded = 1'b1;
`endif
      m_l = nl; m_r = nr; m_t = nt; m_b = nb;
    end
    e = {ok, 19'(cnt), 10'(m_l), 10'(m_r), 10'(m_t), 10'(m_b)};
  endtask

  // ---------------- image builders ----------------
  task automatic clear_img();
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) img[y][x] = 1'b0;
  endtask

  task automatic add_rect(input int x0, input int x1, input int y0, input int y1);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) img[y][x] = 1'b1;
  endtask

  task automatic random_img(input int pct_noise);
    int nrect, x0, y0, w, hh;
    clear_img();
    nrect = $urandom_range(0, 3);
    for (int i = 0; i < nrect; i++) begin
      w  = $urandom_range(1, 30);
      hh = $urandom_range(1, 25);
      x0 = $urandom_range(0, H - w);
      y0 = $urandom_range(0, V - hh);
      add_rect(x0, x0 + w - 1, y0, y0 + hh - 1);
    end
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        if ($urandom_range(0, 99) < pct_noise) img[y][x] = 1'b1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_sample(input int x, input int y, input logic [11:0] d, input bit en);
    @(posedge clk); #1;
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    img_data = d;
    pixel_en = en;
    if (en && x == 0 && y == 0) synced = 1'b1;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    pixel_en = 1'b0;
    img_data = 12'hfff;
  endtask

  // Drive lines y0..y1. half: random disabled duplicates; blank: out-of-range
  // samples with pixel_en high between lines and after the frame.
  task automatic drive_rows(input int y0, input int y1, input bit half, input bit blank);
    logic [59:0] e;
    logic [11:0] d;
    for (int y = y0; y <= y1; y++) begin
      for (int x = 0; x < H; x++) begin
        d = img[y][x] ? 12'hfff : 12'($urandom_range(0, 4094));
        if (x == H - 1 && y == V - 1 && synced) begin
          model_frame(e);
          exp_q.push_back(e);
        end
        if (half && $urandom_range(0, 1) == 1) drive_sample(x, y, d, 1'b0);
        drive_sample(x, y, d, 1'b1);
      end
      if (blank) begin
        drive_sample(H, y, 12'hfff, 1'b1);
        drive_sample(H + 1 + $urandom_range(0, 100), y, 12'hfff, 1'b1);
      end
    end
    if (blank) drive_sample(0, V, 12'hfff, 1'b1);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst      = 1'b1;
    pixel_en = 1'b0;
    exp_q.delete();
    mon_hold = reset_vec();
    synced   = 1'b0;
    m_l = 0; m_r = H - 1; m_t = 0; m_b = V - 1;
`ifdef HAND_BBOX_SMOOTH_EN
    m_seeded = 1'b0;
`endif
    #1;
    check_vec("reset_outputs", {bbox_valid, pixel_count, left, right, top, bottom}, reset_vec());
    check_bit("reset_frame_done", frame_done, 1'b0);
    check_bit("reset_fsm_sync", dbg_accum_o, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [59:0] got, e;
    got = {bbox_valid, pixel_count, left, right, top, bottom};
    if (!rst) begin
      if (frame_done) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL frame_done_unexpected got pulse with %s required no pulse", show(got));
        end else begin
          e = exp_q.pop_front();
          mon_hold = e;
          if (got !== e) begin
            errors++;
            $display("FAIL frame_result got %s required %s", show(got), show(e));
          end
        end
      end else begin
        checks++;
        if (got !== mon_hold) begin
          errors++;
          if (stab_msgs < 10)
            $display("FAIL outputs_held got %s required %s", show(got), show(mon_hold));
          stab_msgs++;
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #3_000_000;
    $display("FAIL watchdog time limit reached, checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    apply_reset();

    // Partial frame after reset: must not produce frame_done.
    clear_img(); add_rect(20, 39, 25, 40);
    drive_rows(20, V - 1, 1'b0, 1'b0);
    idle();
    check_bit("partial_fsm_sync", dbg_accum_o, 1'b0);

    // Back-to-back full frames.
    clear_img(); add_rect(20, 39, 10, 24);                // valid box, top clamped to 0
    drive_rows(0, V - 1, 1'b0, 1'b0);
    clear_img();                                          // only 3-pixel runs: rejected
    for (int y = 0; y < V; y += 2)
      for (int x = 1; x + 2 < H; x += 6) add_rect(x, x + 2, y, y);
    drive_rows(0, V - 1, 1'b0, 1'b0);
    clear_img(); add_rect(0, 20, 35, V - 1);              // left/bottom clamping
    drive_rows(0, V - 1, 1'b0, 1'b0);
    clear_img(); add_rect(50, H - 1, 0, 19);              // right/top clamping
    drive_rows(0, V - 1, 1'b0, 1'b0);
    idle();
    check_bit("fsm_accum", dbg_accum_o, 1'b1);

    // Threshold frames, with blanking samples that must be ignored.
    clear_img(); add_rect(30, 42, 5, 19);                 // 15 x 10 = 150: rejected
    drive_rows(0, V - 1, 1'b0, 1'b1);
    clear_img(); add_rect(30, 42, 5, 24);                 // 20 x 10 = 200: accepted
    drive_rows(0, V - 1, 1'b0, 1'b1);
    clear_img(); add_rect(10, 22, 20, 38); add_rect(10, 21, 39, 39);  // 199: rejected
    drive_rows(0, V - 1, 1'b0, 1'b1);
    clear_img(); add_rect(5, 60, 3, 44);                  // wide box
    drive_rows(0, V - 1, 1'b0, 1'b0);

    // pixel_en toggling with duplicated samples.
    clear_img(); add_rect(20, 39, 10, 24);
    drive_rows(0, V - 1, 1'b1, 1'b0);
    random_img(2);
    drive_rows(0, V - 1, 1'b1, 1'b1);

    // Randomized frames.
    for (int f = 0; f < 3; f++) begin
      random_img($urandom_range(0, 4));
      drive_rows(0, V - 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    idle();

    // Reset in the middle of a frame.
    clear_img(); add_rect(25, 55, 12, 40);
    drive_rows(0, 20, 1'b0, 1'b0);
    apply_reset();
    drive_rows(21, V - 1, 1'b0, 1'b0);
    idle();
    check_bit("post_reset_fsm_sync", dbg_accum_o, 1'b0);
    drive_rows(0, V - 1, 1'b0, 1'b0);
    idle();

    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_results got %0d unseen frame_done required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
